// File: rtl/canvas_reader.sv
// canvas_reader: scans the 32x32 canvas, 2x2 OR-downsamples to 16 row words, counts set pixels
module canvas_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        editing,
  output logic [9:0]  rd_addr,
  output logic        rd_en,
  input  logic        rd_data,
  output logic [15:0] out_row,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [10:0] pixel_count
);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, FIN} state_t;
  state_t r_state, w_next;
  logic [3:0]  r_row;
  logic [5:0]  r_cnt;
  logic [15:0] r_acc;
  logic [10:0] r_pix;
  logic [READ_LATENCY-1:0] r_vld;
  logic [3:0]  r_tag [READ_LATENCY];
  logic        w_cap;
  logic [3:0]  w_tag;
  assign w_cap       = r_vld[READ_LATENCY-1];
  assign w_tag       = r_tag[READ_LATENCY-1];
  assign rd_en       = r_state == READ;
  assign rd_addr     = {r_row, r_cnt};
  assign out_valid   = r_state == OUT;
  assign out_row     = out_valid ? r_acc : '0;
  assign out_idx     = r_row;
  assign out_last    = out_valid && r_row == 4'd15;
  assign busy        = r_state != IDLE;
  assign done        = r_state == FIN;
  assign pixel_count = r_pix;
  // next-state: 64 reads per row pair, drain the read pipeline, then hold the row until accepted
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (start && !editing) ? READ : IDLE;
      READ:    w_next = (r_cnt == 6'd63) ? DRAIN : READ;
      DRAIN:   w_next = (r_cnt == 6'(READ_LATENCY - 1)) ? OUT : DRAIN;
      OUT:     w_next = !out_ready ? OUT : (r_row == 4'd15) ? FIN : READ;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state, counters, x-tag pipeline matching the RAM latency, and row/pixel accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_pix   <= '0;
      r_vld   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_state  <= w_next;
      r_vld[0] <= rd_en;
      r_tag[0] <= r_cnt[4:1];
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_tag[k] <= r_tag[k-1];
      end
      if (r_state == READ || r_state == DRAIN)
        r_cnt <= (r_state == DRAIN && w_next == OUT) ? '0 : r_cnt + 6'd1;
      if (r_state == IDLE && w_next == READ) begin
        r_row <= '0;
        r_acc <= '0;
        r_pix <= '0;
      end else begin
        if (w_cap) begin
          r_acc[w_tag] <= r_acc[w_tag] | rd_data;
          r_pix        <= r_pix + 11'(rd_data);
        end
        if (r_state == OUT && w_next == READ) begin
          r_row <= r_row + 4'd1;
          r_acc <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_canvas_reader.sv
// tb_canvas_reader: randomized scoreboard bench for canvas_reader at read latency 1 and 2
module tb_canvas_reader;
  typedef struct {logic [15:0] row; logic [3:0] idx; logic last;} exp_t;
  logic clk = 0, rst = 1, start = 0, editing = 0, rdy1 = 1;
  logic [9:0]  a_rd_addr, b_rd_addr;
  logic        a_rd_en, b_rd_en, a_q, b_q1, b_q2;
  logic [15:0] a_out_row, b_out_row;
  logic [3:0]  a_out_idx, b_out_idx;
  logic        a_out_valid, b_out_valid, a_out_last, b_out_last;
  logic        a_busy, b_busy, a_done, b_done;
  logic [10:0] a_pixel_count, b_pixel_count;
  bit          mem [1024];
  exp_t        exp_a[$], exp_b[$], ea, eb;
  int          cnt_a[$], cnt_b[$];
  int          total = 0, bad = 0, na_done = 0, nb_done = 0;
  always #5 clk = ~clk;
  canvas_reader #(.READ_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .editing(editing), .rd_addr(a_rd_addr), .rd_en(a_rd_en),
    .rd_data(a_q), .out_row(a_out_row), .out_idx(a_out_idx), .out_valid(a_out_valid),
    .out_ready(rdy1), .out_last(a_out_last), .busy(a_busy), .done(a_done), .pixel_count(a_pixel_count));
  canvas_reader #(.READ_LATENCY(2)) u_b (
    .clk(clk), .rst(rst), .start(start), .editing(editing), .rd_addr(b_rd_addr), .rd_en(b_rd_en),
    .rd_data(b_q2), .out_row(b_out_row), .out_idx(b_out_idx), .out_valid(b_out_valid),
    .out_ready(1'b1), .out_last(b_out_last), .busy(b_busy), .done(b_done), .pixel_count(b_pixel_count));
  // canvas RAM models; unenabled reads return noise so stray captures show up
  always @(posedge clk) begin
    a_q  <= a_rd_en ? mem[a_rd_addr] : 1'($urandom);
    b_q1 <= b_rd_en ? mem[b_rd_addr] : 1'($urandom);
    b_q2 <= b_q1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask
  // monitors: pop expected rows on each handshake, expected count on each done
  always @(negedge clk) if (!rst) begin
    if (a_out_valid && rdy1) begin
      if (exp_a.size() == 0) begin
        total++; bad++; $display("FAIL a_extra_row: got idx %0d with nothing expected", a_out_idx);
      end else begin
        ea = exp_a.pop_front();
        chk("a_row", a_out_row, ea.row); chk("a_idx", a_out_idx, ea.idx); chk("a_last", a_out_last, ea.last);
      end
    end
    if (b_out_valid) begin
      if (exp_b.size() == 0) begin
        total++; bad++; $display("FAIL b_extra_row: got idx %0d with nothing expected", b_out_idx);
      end else begin
        eb = exp_b.pop_front();
        chk("b_row", b_out_row, eb.row); chk("b_idx", b_out_idx, eb.idx); chk("b_last", b_out_last, eb.last);
      end
    end
    if (a_done) begin
      na_done++;
      if (cnt_a.size() == 0) begin total++; bad++; $display("FAIL a_extra_done: got done, none expected"); end
      else chk("a_pix", a_pixel_count, cnt_a.pop_front());
    end
    if (b_done) begin
      nb_done++;
      if (cnt_b.size() == 0) begin total++; bad++; $display("FAIL b_extra_done: got done, none expected"); end
      else chk("b_pix", b_pixel_count, cnt_b.pop_front());
    end
  end
  task automatic push_exp();
    exp_t e;
    int pc = 0;
    for (int r = 0; r < 16; r++) begin
      e.row = '0; e.idx = 4'(r); e.last = (r == 15);
      for (int i = 0; i < 16; i++)
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            if (mem[(2 * r + dy) * 32 + 2 * i + dx]) e.row[i] = 1'b1;
      exp_a.push_back(e); exp_b.push_back(e);
    end
    foreach (mem[j]) pc += int'(mem[j]);
    cnt_a.push_back(pc); cnt_b.push_back(pc);
  endtask
  task automatic fill(input int kind);
    foreach (mem[j]) mem[j] = (kind == 1) ? 1'b1 : (kind == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask
  task automatic chk_reset();
    chk("rst_addr", a_rd_addr, 0); chk("rst_en", a_rd_en, 0); chk("rst_row", a_out_row, 0);
    chk("rst_idx", a_out_idx, 0); chk("rst_valid", a_out_valid, 0); chk("rst_last", a_out_last, 0);
    chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0); chk("rst_pix", a_pixel_count, 0);
    chk("rst_b_busy", b_busy, 0); chk("rst_b_pix", b_pixel_count, 0);
  endtask
  // mode 0 plain, 1 ten-cycle stall on row 3, 2 random ready, 3 extra start and editing mid-scan
  task automatic do_scan(input int mode);
    int ta = 0, tb = 0, k = 0, ph = 0;
    logic [15:0] hr;
    @(posedge clk); #1 start = 1; push_exp();
    @(posedge clk); #1 start = 0;
    for (int n = 1; n < 4000 && (ta == 0 || tb == 0); n++) begin
      @(posedge clk); #1;
      if (a_done && ta == 0) ta = n;
      if (b_done && tb == 0) tb = n;
      if (mode == 2) rdy1 = 1'($urandom_range(0, 1));
      if (mode == 3) begin start = (n == 100); editing = (n >= 200 && n < 300); end
      if (mode == 1) begin
        if (ph == 0 && a_rd_en && a_rd_addr[9:6] == 4'd3) begin ph = 1; rdy1 = 0; end
        else if (ph == 1 && a_out_valid) begin hr = a_out_row; k = 1; ph = 2; chk("stall_idx", a_out_idx, 3); end
        else if (ph == 2) begin
          chk("stall_row", a_out_row, hr); chk("stall_valid", a_out_valid, 1);
          chk("stall_held_idx", a_out_idx, 3); chk("stall_rd_en", a_rd_en, 0);
          k++;
          if (k == 11) begin rdy1 = 1; ph = 3; end
        end
      end
    end
    rdy1 = 1; start = 0; editing = 0;
    if (ta == 0 || tb == 0) begin total++; bad++; $display("FAIL scan_timeout: done a=%0d b=%0d, both required", ta, tb); end
    if (mode != 2) chk("a_done_time", ta, 16 * 66 + (mode == 1 ? 10 : 0));
    chk("b_done_time", tb, 16 * 67);
    @(posedge clk); #1;
    chk("a_queue_empty", exp_a.size() + cnt_a.size(), 0);
    chk("b_queue_empty", exp_b.size() + cnt_b.size(), 0);
    chk("a_idle_after", a_busy, 0);
  endtask
  initial begin
    int da, db, n;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst = 0;
    fill(0); do_scan(0);
    mem[10'h0A7] = 1'b1; do_scan(0);
    fill(1); do_scan(0);
    fill(2); do_scan(1);
    editing = 1; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) begin @(posedge clk); #1 chk("edit_busy", a_busy, 0); chk("edit_rd_en", a_rd_en | b_rd_en, 0); end
    editing = 0;
    repeat (3) begin @(posedge clk); #1 chk("edit_not_queued", a_busy | b_busy, 0); end
    fill(2); do_scan(3);
    fill(2); do_scan(2);
    fill(2); do_scan(2);
    fill(2); mem[0] = 1'b1;
    @(posedge clk); #1 start = 1; push_exp();
    @(posedge clk); #1 start = 0;
    n = 0;
    while (!(a_rd_en && a_rd_addr[9:6] == 4'd8) && n < 2000) begin @(posedge clk); #1 n++; end
    chk("row8_reached", n < 2000, 1);
    rst = 1; da = na_done; db = nb_done;
    @(posedge clk); #1 chk_reset();
    exp_a.delete(); exp_b.delete(); cnt_a.delete(); cnt_b.delete();
    rst = 0;
    repeat (1200) @(posedge clk);
    #1 chk("no_done_after_rst", na_done + nb_done, da + db);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/canvas_reader.md
Name: canvas_reader

Overview:
Reads back the 32x32 one-bit drawing canvas written by the mouse path through the canvas RAM read port. It downsamples the canvas 2x2 to 16x16 by OR-ing each 2x2 cell group. It streams the result as 16 row words over a valid/ready handshake and counts the set pixels. It sits between the canvas RAM and the downstream consumer (glyph matcher / preview renderer).

Parameters:
READ_LATENCY, 1, canvas RAM read latency in cycles; legal values 1 or 2.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  scan request pulse; accepted only in IDLE with editing low
editing  input  1  mouse path is mid-stroke; blocks start acceptance
rd_addr  output  10  canvas read address {y[4:0], x[4:0]}
rd_en  output  1  read strobe
rd_data  input  1  canvas bit; valid READ_LATENCY cycles after the rd_en cycle
out_row  output  16  downsampled row; bit i = OR of canvas (2r..2r+1, 2i..2i+1)
out_idx  output  4  row index r of out_row
out_valid  output  1  out_row/out_idx valid
out_ready  input  1  consumer accepts the row when out_valid and out_ready are both high
out_last  output  1  high with out_valid when out_idx==15
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the row-15 handshake
pixel_count  output  11  set-pixel count over all 1024 bits; 0..1024

Behaviour:
- Reset values: state IDLE; rd_addr 0; rd_en 0; out_row 0; out_idx 0; out_valid 0; out_last 0; busy 0; done 0; pixel_count 0.
- Reset mid-scan aborts immediately; no done pulse is issued.
- States: IDLE, READ, DRAIN, OUT, FIN.
- IDLE:
  - start && !editing -> READ; row counter r=0; row accumulator acc=0; pixel_count=0.
  - start while editing is ignored and not queued.
  - start while busy is ignored.
- READ issues 64 consecutive reads, one per cycle, rd_en=1.
  - Order: y=2r, x=0..31, then y=2r+1, x=0..31.
  - rd_addr = {y, x}.
  - The address, x, y and r counters form a pipeline matching READ_LATENCY. Returned data is tagged with its x through a READ_LATENCY-deep shift register.
- Data capture, for every returned bit:
  - acc[x>>1] |= rd_data.
  - pixel_count += rd_data (11-bit; cannot overflow, max 1024).
- After the 64th read issue -> DRAIN, rd_en=0, for READ_LATENCY cycles until the last bit is captured.
- DRAIN -> OUT: out_row=acc, out_idx=r, out_valid=1, out_last=(r==15).
- OUT holds all outputs stable until out_ready.
  - On the handshake cycle, out_valid drops the next cycle.
  - If r==15 -> FIN; otherwise r++, acc=0, -> READ.
  - No reads are issued while in OUT (full backpressure; no prefetch).
  - out_ready high while out_valid is low has no effect.
- FIN: done=1 for exactly one cycle -> IDLE.
  - pixel_count holds its value until the next accepted start.
- Timing with out_ready tied high and READ_LATENCY=1:
  - Per row: 64 READ + 1 DRAIN + 1 OUT = 66 cycles.
  - Full scan: 16 x 66 = 1056 cycles from the start-accept edge to FIN; done is asserted in cycle 1057.
- editing rising during a scan does not alter or abort it. Consistency is the scheduler's responsibility.
- A start pulse in the same cycle as FIN's done is ignored (state is not yet IDLE).

Test Plan:
- Empty canvas, start, out_ready=1 -> 16 rows, all out_row=16'h0000; out_idx 0..15; out_last only on idx 15; pixel_count=0; done 1057 cycles after start with READ_LATENCY=1.
- Single pixel at y=5, x=7 (addr 10'h0A7) -> row idx 2 = 16'h0008; all other rows 0; pixel_count=1.
- Full canvas (all 1s) -> every out_row=16'hFFFF; pixel_count=1024.
- Backpressure: out_ready low for 10 cycles on row 3 -> out_row, out_idx and out_valid held stable; rd_en=0 throughout; the scan resumes after the handshake; total scan is 10 cycles longer.
- Start with editing=1 -> busy stays 0 and no reads are issued. Then start with editing=0 -> accepted. A second start mid-scan -> ignored.
- rst asserted at row 8 mid-READ -> next cycle all outputs at reset values, done never pulses. Repeat the single-pixel test with READ_LATENCY=2 -> identical row results.
